// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and state type for the fetch stage.
package fetch_pkg;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC = 32'd4;
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} fetch_state_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction memory request/response bus.
interface fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_data;
    modport master (output imem_req, imem_addr, input imem_ready, imem_data);
    modport slave (input imem_req, imem_addr, output imem_ready, imem_data);
endinterface

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry buffer holding a word fetched while decode stalls.
module fetch_skid_buf (
    input  logic        clk,
    input  logic        clr,
    input  logic        load,
    input  logic        unload,
    input  logic        discard,
    input  logic [31:0] in_data,
    input  logic [31:0] in_pc4,
    output logic [31:0] data,
    output logic [31:0] pc4,
    output logic        full
);
    always_ff @(posedge clk or negedge clr)
        if (!clr) begin
            data <= '0;
            pc4  <= '0;
            full <= 1'b0;
        end else begin
            if (load) begin
                data <= in_data;
                pc4  <= in_pc4;
            end
            full <= load ? 1'b1 : (unload || discard) ? 1'b0 : full;
        end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, fetch FSM and IF/ID register.
// Define FETCH_PERF_CNT_EN to add the fetch_count output.
module fetch_stage import fetch_pkg::*; #(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    fetch_if.master     imem,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);
    fetch_state_t state, state_next;
    logic [31:0] pc, pc_next, pc_inc, drain_addr, skid_data, skid_pc4;
    logic ld_ifid, use_skid, kill, skid_ld, skid_unld, skid_disc, drain_ld, skid_full;

    assign pc_inc = pc + PC_INC;
    assign imem.imem_req = clr && state == FETCH;
    // the abandoned request keeps its address on the bus until memory answers it
    assign imem.imem_addr = state == DRAIN ? drain_addr : pc;

    always_comb begin
        state_next = state;
        pc_next = pc;
        ld_ifid = 1'b0;
        use_skid = 1'b0;
        kill = 1'b0;
        skid_ld = 1'b0;
        skid_unld = 1'b0;
        skid_disc = 1'b0;
        drain_ld = 1'b0;
        if (branch_taken) begin
            pc_next = branch_target & ~32'h3;
            kill = 1'b1;
            skid_disc = 1'b1;
            drain_ld = state == FETCH && !imem.imem_ready;
            state_next = (state != HOLD && !imem.imem_ready) ? DRAIN : FETCH;
        end else begin
            case (state)
                FETCH: begin
                    pc_next = imem.imem_ready ? pc_inc : pc;
                    skid_ld = imem.imem_ready && stall;
                    ld_ifid = imem.imem_ready && !stall;
                    kill = !imem.imem_ready && !stall;
                    state_next = skid_ld ? HOLD : FETCH;
                end
                HOLD: begin
                    ld_ifid = !stall && skid_full;
                    use_skid = 1'b1;
                    skid_unld = ld_ifid;
                    state_next = stall ? HOLD : FETCH;
                end
                default: state_next = imem.imem_ready ? FETCH : DRAIN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr)
        if (!clr) begin
            state      <= FETCH;
            pc         <= PC_RESET;
            drain_addr <= PC_RESET;
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_pc4   <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (drain_ld) drain_addr <= pc;
            if (ld_ifid) begin
                ifid_valid <= 1'b1;
                ifid_instr <= use_skid ? skid_data : imem.imem_data;
                ifid_pc4   <= use_skid ? skid_pc4 : pc_inc;
            end else if (kill) begin
                ifid_valid <= 1'b0;
            end
        end

    fetch_skid_buf u_skid (
        .clk(clk),
        .clr(clr),
        .load(skid_ld),
        .unload(skid_unld),
        .discard(skid_disc),
        .in_data(imem.imem_data),
        .in_pc4(pc_inc),
        .data(skid_data),
        .pc4(skid_pc4),
        .full(skid_full)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge clr)
        if (!clr) fetch_count <= '0;
        else if (ld_ifid) fetch_count <= fetch_count + 32'd1;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage; memory returns E0000001 + addr/4.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic clr = 1'b0;
    logic stall = 1'b0;
    logic branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic ready = 1'b0;
    logic ifid_valid;
    logic [31:0] ifid_instr, ifid_pc4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif
    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    fetch_if bus();
    assign bus.imem_ready = ready;
    assign bus.imem_data = 32'hE000_0001 + (bus.imem_addr >> 2);

    fetch_stage dut (
        .clk(clk),
        .clr(clr),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .imem(bus.master),
        .ifid_valid(ifid_valid),
        .ifid_instr(ifid_instr),
        .ifid_pc4(ifid_pc4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count(fetch_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one clock: drive inputs, predict accepted word, then compare any new IF/ID load
    task automatic step(input logic s, input logic b, input logic [31:0] t, input logic r);
        logic [63:0] e;
        stall = s;
        branch_taken = b;
        branch_target = t;
        ready = r;
        #1;
        if (b) exp_q.delete();
        else if (bus.imem_req && bus.imem_ready) exp_q.push_back({bus.imem_data, bus.imem_addr + 32'd4});
        @(negedge clk);
        if (ifid_valid && !s) begin
            if (exp_q.size() == 0) chk("unexpected_load", {ifid_instr, ifid_pc4}, 64'h0);
            else begin
                e = exp_q.pop_front();
                chk("ifid_instr", {32'h0, ifid_instr}, {32'h0, e[63:32]});
                chk("ifid_pc4", {32'h0, ifid_pc4}, {32'h0, e[31:0]});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_req", {63'h0, bus.imem_req}, 64'h0);
        chk("rst_valid", {63'h0, ifid_valid}, 64'h0);
        chk("rst_instr", {32'h0, ifid_instr}, 64'h0);
        chk("rst_pc4", {32'h0, ifid_pc4}, 64'h0);
        clr = 1'b1;
        #1;
        chk("first_req", {63'h0, bus.imem_req}, 64'h1);
        chk("first_addr", {32'h0, bus.imem_addr}, 64'h0);
        // streaming, zero-wait memory
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1);
            chk("stream_addr", {32'h0, bus.imem_addr}, 4 * (i + 1));
            chk("stream_valid", {63'h0, ifid_valid}, 64'h1);
        end
        // stall with ready: one word skids, IF/ID frozen
        step(1, 0, 0, 1);
        chk("hold_req", {63'h0, bus.imem_req}, 64'h0);
        chk("hold_pc4", {32'h0, ifid_pc4}, 64'h10);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("hold_req2", {63'h0, bus.imem_req}, 64'h0);
        chk("hold_instr", {32'h0, ifid_instr}, 64'hE000_0004);
        step(0, 0, 0, 1);
        chk("unload_pc4", {32'h0, ifid_pc4}, 64'h14);
        step(0, 0, 0, 1);
        // branch during stall discards skid
        step(1, 0, 0, 1);
        step(1, 1, 32'h100, 1);
        chk("br_valid", {63'h0, ifid_valid}, 64'h0);
        chk("br_addr", {32'h0, bus.imem_addr}, 64'h100);
        chk("br_req", {63'h0, bus.imem_req}, 64'h1);
        step(0, 0, 0, 1);
        chk("br_pc4", {32'h0, ifid_pc4}, 64'h104);
        // memory wait, then branch into DRAIN
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("wait_valid", {63'h0, ifid_valid}, 64'h0);
        chk("wait_addr", {32'h0, bus.imem_addr}, 64'h104);
        chk("wait_pc4", {32'h0, ifid_pc4}, 64'h104);
        step(0, 1, 32'h40, 0);
        chk("drain_req", {63'h0, bus.imem_req}, 64'h0);
        chk("drain_addr", {32'h0, bus.imem_addr}, 64'h104);
        step(0, 0, 0, 1);
        chk("drain_drop_valid", {63'h0, ifid_valid}, 64'h0);
        chk("drain_exit_addr", {32'h0, bus.imem_addr}, 64'h40);
        step(0, 0, 0, 1);
        chk("after_drain_pc4", {32'h0, ifid_pc4}, 64'h44);
        // second branch while draining only moves pc
        step(0, 1, 32'h80, 0);
        step(0, 1, 32'h200, 0);
        chk("drain2_addr", {32'h0, bus.imem_addr}, 64'h44);
        chk("drain2_req", {63'h0, bus.imem_req}, 64'h0);
        step(0, 0, 0, 1);
        chk("drain2_exit_addr", {32'h0, bus.imem_addr}, 64'h200);
        step(0, 0, 0, 1);
        // top-of-memory wrap, low target bits ignored
        step(0, 1, 32'hFFFF_FFFF, 1);
        chk("wrap_addr", {32'h0, bus.imem_addr}, 64'hFFFF_FFFC);
        step(0, 0, 0, 1);
        chk("wrap_pc4", {32'h0, ifid_pc4}, 64'h0);
        chk("wrap_next_addr", {32'h0, bus.imem_addr}, 64'h0);
        chk("no_loss", exp_q.size(), 64'h0);
        // asynchronous reset in the middle of HOLD
        step(1, 0, 0, 1);
        stall = 1'b0;
        #2 clr = 1'b0;
        #1;
        chk("clr_req", {63'h0, bus.imem_req}, 64'h0);
        chk("clr_valid", {63'h0, ifid_valid}, 64'h0);
        chk("clr_instr", {32'h0, ifid_instr}, 64'h0);
        chk("clr_pc4", {32'h0, ifid_pc4}, 64'h0);
        chk("clr_addr", {32'h0, bus.imem_addr}, 64'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("clr_count", {32'h0, fetch_count}, 64'h0);
`endif
        exp_q.delete();
        @(negedge clk);
        clr = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        chk("post_clr_pc4", {32'h0, ifid_pc4}, 64'hC);
`ifdef FETCH_PERF_CNT_EN
        chk("count", {32'h0, fetch_count}, 64'h3);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
